layer_sequencer: RTL and testbench
==================================

Name: layer_sequencer

Overview:
- Upstream driver for one neuron_ip instance.
- Accepts the layer's activation bytes as a valid/ready stream and packs them into the neuron's input bus.
- For each neuron in the layer: fetches that neuron's weight row and bias from a synchronous weight memory, pulses start, waits for the neuron to finish, and emits the 8-bit result as an indexed output stream.
- Time-multiplexes one neuron over NEURON_COUNT neurons, then signals layer completion.

Parameters:
- INPUT_COUNT, 62, activations per layer; sets the neuron input/weight bus width to INPUT_COUNT*8.
- NEURON_COUNT, 30, neurons evaluated per layer pass.
- IDX_WIDTH, 8, width of neuron index and weight address; requires NEURON_COUNT <= 2^IDX_WIDTH.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- layer_ctrl  in  2  activation select; forwarded unchanged to the neuron's ctrl_data.
- in_valid  in  1  activation byte valid.
- in_data  in  8  activation byte.
- in_ready  out  1  sequencer can accept an activation byte.
- w_rd_en  out  1  weight memory read strobe.
- w_addr  out  IDX_WIDTH  weight row address (= neuron index).
- w_data  in  INPUT_COUNT*8+8  read row: bits [INPUT_COUNT*8-1:0] weights, top 8 bits bias; valid exactly 1 cycle after w_rd_en.
- n_inputs  out  INPUT_COUNT*8  packed activations to the neuron's inputs.
- n_weights  out  INPUT_COUNT*8  registered weight row to the neuron's weights.
- n_bias  out  8  registered bias to the neuron's bias.
- n_ctrl_data  out  2  equals layer_ctrl.
- n_start  out  1  one-cycle start pulse to the neuron's start_signal.
- n_ready  in  1  the neuron's ready_signal.
- n_out  in  8  neuron result.
- out_valid  out  1  result available.
- out_data  out  8  captured n_out.
- out_index  out  IDX_WIDTH  neuron index of out_data.
- out_ready  in  1  consumer accepts result.
- layer_done  out  1  one-cycle pulse after the last result is accepted.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=IDLE; byte counter and neuron index = 0.
  - n_inputs, n_weights, n_bias, out_data, out_index = 0.
  - n_start, w_rd_en, out_valid, layer_done = 0.
  - Release takes effect on the next clk edge.
- Packing: the k-th accepted byte (k = 0..INPUT_COUNT-1) is written to n_inputs[k*8+7:k*8]. n_inputs holds until the next layer's loading begins.
- States:
  - IDLE: in_ready=1. An accepted byte is stored at k=0; go to LOAD, or to FETCH if INPUT_COUNT==1.
  - LOAD: in_ready=1. Bytes are accepted when in_valid&in_ready. On acceptance of byte INPUT_COUNT-1, go to FETCH. No bytes are dropped or duplicated across valid gaps.
  - FETCH: in_ready=0, w_rd_en=1, w_addr=neuron index, for 1 cycle; go to WAIT_MEM.
  - WAIT_MEM: register w_data into n_weights/n_bias; go to START.
  - START: n_start=1 for exactly 1 cycle; go to BLANK.
  - BLANK: n_ready is ignored for this 1 cycle (the neuron drops ready only after sampling start); go to RUN.
  - RUN: wait for n_ready=1. In that cycle capture n_out into out_data, set out_index=neuron index, assert out_valid; go to EMIT.
  - EMIT: out_valid, out_data and out_index are held stable until out_valid&out_ready.
    - On handshake with index < NEURON_COUNT-1: index++, go to FETCH.
    - On handshake with index = NEURON_COUNT-1: layer_done=1 for that following cycle, index=0, go to IDLE.
- n_weights, n_bias and n_inputs are stable from START through the end of RUN.
- Latency per neuron, excluding neuron compute and backpressure: FETCH→START = 2 cycles; n_ready high → out_valid = 1 cycle.
- in_ready=0 in every state except IDLE and LOAD. Bytes offered then are not consumed.
- out_ready while out_valid=0 is ignored.
- n_ready already high in START/BLANK is not treated as completion.
- The index wraps only through the DONE path; it never exceeds NEURON_COUNT-1.

Test Plan:
- Load 62 bytes 0x01..0x3E with in_valid continuous → in_ready drops the cycle after byte 62; n_inputs[7:0]=0x01 and n_inputs[495:488]=0x3E; w_rd_en pulses with w_addr=0.
- Neuron model returns ready 5 cycles after start with n_out=0x7F, out_ready=1 → out_valid for 1 cycle, out_data=0x7F, out_index=0; next w_addr=1; n_start width exactly 1 cycle.
- Hold out_ready=0 for 10 cycles during EMIT → out_data and out_index stable, no new w_rd_en; out_ready=1 → FETCH the next cycle.
- Full layer with NEURON_COUNT=3 → out_index sequence 0,1,2, then one layer_done pulse; in_ready=1 the cycle after layer_done.
- In_valid toggled every other cycle during LOAD → exactly 62 bytes packed in order, no skips.
- rst_n low during RUN of neuron 1 → all outputs 0 immediately without waiting for clk; after release, in_ready=1 and a new layer starts at neuron 0.

Source files
------------

// File: rtl/layer_sequencer.sv
// rtl/layer_sequencer.sv - packs activations, fetches weights and time-multiplexes one neuron across a layer
module layer_sequencer #(
  parameter int INPUT_COUNT  = 62,
  parameter int NEURON_COUNT = 30,
  parameter int IDX_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                layer_ctrl,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  output logic                      in_ready,
  output logic                      w_rd_en,
  output logic [IDX_WIDTH-1:0]      w_addr,
  input  logic [INPUT_COUNT*8+7:0]  w_data,
  output logic [INPUT_COUNT*8-1:0]  n_inputs,
  output logic [INPUT_COUNT*8-1:0]  n_weights,
  output logic [7:0]                n_bias,
  output logic [1:0]                n_ctrl_data,
  output logic                      n_start,
  input  logic                      n_ready,
  input  logic [7:0]                n_out,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic [IDX_WIDTH-1:0]      out_index,
  input  logic                      out_ready,
  output logic                      layer_done
);

  localparam int CNT_W = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE   = CNT_W'(INPUT_COUNT - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_NEURON = IDX_WIDTH'(NEURON_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_FETCH    = 3'd2,
    S_WAIT_MEM = 3'd3,
    S_START    = 3'd4,
    S_BLANK    = 3'd5,
    S_RUN      = 3'd6,
    S_EMIT     = 3'd7
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     byte_cnt;
  logic [IDX_WIDTH-1:0] idx;

  // Strobes are pure decodes of the state register, so they are glitch-free and one cycle wide
  always_comb begin
    in_ready    = (state == S_IDLE) || (state == S_LOAD);
    w_rd_en     = (state == S_FETCH);
    w_addr      = idx;
    n_start     = (state == S_START);
    n_ctrl_data = layer_ctrl;
  end

  // Main sequencer: byte packing, weight fetch, neuron handshake and result emission
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      idx        <= '0;
      n_inputs   <= '0;
      n_weights  <= '0;
      n_bias     <= '0;
      out_data   <= '0;
      out_index  <= '0;
      out_valid  <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            n_inputs[7:0] <= in_data;
            if (INPUT_COUNT == 1) begin
              state <= S_FETCH;
            end else begin
              byte_cnt <= CNT_W'(1);
              state    <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            n_inputs[{byte_cnt, 3'b000} +: 8] <= in_data;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= S_FETCH;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
        end
        S_FETCH: begin
          state <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          // Memory answers exactly one cycle after the read strobe
          n_weights <= w_data[INPUT_COUNT*8-1:0];
          n_bias    <= w_data[INPUT_COUNT*8 +: 8];
          state     <= S_START;
        end
        S_START: begin
          state <= S_BLANK;
        end
        S_BLANK: begin
          // The neuron may still show its stale ready here; it only drops after sampling start
          state <= S_RUN;
        end
        S_RUN: begin
          if (n_ready) begin
            out_data  <= n_out;
            out_index <= idx;
            out_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_NEURON) begin
              idx        <= '0;
              layer_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              idx   <= idx + IDX_WIDTH'(1);
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb/tb_layer_sequencer.sv - directed self-checking bench for layer_sequencer
module tb_layer_sequencer;

  localparam int IC = 62;
  localparam int NC = 3;
  localparam int IW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        layer_ctrl;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              w_rd_en;
  logic [IW-1:0]     w_addr;
  logic [IC*8+7:0]   w_data;
  logic [IC*8-1:0]   n_inputs;
  logic [IC*8-1:0]   n_weights;
  logic [7:0]        n_bias;
  logic [1:0]        n_ctrl_data;
  logic              n_start;
  logic              n_ready;
  logic [7:0]        n_out;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [IW-1:0]     out_index;
  logic              out_ready;
  logic              layer_done;

  int total = 0;
  int bad = 0;
  logic [IC*8-1:0] exp_inputs;

  always #5 clk = ~clk;

  layer_sequencer #(.INPUT_COUNT(IC), .NEURON_COUNT(NC), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .layer_ctrl(layer_ctrl),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .n_inputs(n_inputs), .n_weights(n_weights), .n_bias(n_bias),
    .n_ctrl_data(n_ctrl_data), .n_start(n_start), .n_ready(n_ready), .n_out(n_out),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_ready(out_ready), .layer_done(layer_done)
  );

  function automatic logic [IC*8+7:0] row(input int a);
    logic [IC*8+7:0] r;
    for (int j = 0; j < IC; j++) r[j*8 +: 8] = 8'(a * 7 + j * 3 + 1);
    r[IC*8 +: 8] = 8'(8'hA0 + a);
    return r;
  endfunction

  // Synchronous weight memory: data one cycle after the read strobe
  always @(posedge clk) if (w_rd_en) w_data <= row(int'(w_addr));

  // Neuron model: keeps ready high through START and BLANK, drops it, then answers 5 cycles later
  logic pend;
  int   ncnt;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_ready = 1'b1; n_out = 8'h00; pend = 1'b0; ncnt = 0;
    end else begin
      if (pend) begin
        pend = 1'b0; n_ready = 1'b0; ncnt = 5;
      end else if (ncnt > 0) begin
        ncnt--;
        if (ncnt == 0) begin
          n_ready = 1'b1;
          n_out   = n_bias ^ 8'hDF;
        end
      end
      if (n_start) pend = 1'b1;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; layer_ctrl = 2'b10; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) tick;
    total++; if (out_valid !== 1'b0 || n_start !== 1'b0 || w_rd_en !== 1'b0 || layer_done !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got ov=%b st=%b rd=%b ld=%b want 0", out_valid, n_start, w_rd_en, layer_done); end
    total++; if (n_inputs !== '0 || n_weights !== '0 || n_bias !== 8'h00 || out_data !== 8'h00 || out_index !== '0) begin
      bad++; $display("FAIL reset_data got bias=%h od=%h oi=%h want 0", n_bias, out_data, out_index); end
    rst_n = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (n_ctrl_data !== 2'b10) begin bad++; $display("FAIL ctrl_forward got %b want 10", n_ctrl_data); end
  endtask

  // Loads IC bytes base+k, optionally with an idle cycle carrying junk before every byte; ends in FETCH
  task automatic test_load(input logic [7:0] base, input bit gap);
    int ready_bad = 0;
    for (int k = 0; k < IC; k++) begin
      if (gap) begin
        in_valid = 1'b0; in_data = 8'hEE;
        tick;
      end
      in_valid = 1'b1; in_data = base + 8'(k);
      exp_inputs[k*8 +: 8] = base + 8'(k);
      if (in_ready !== 1'b1) ready_bad++;
      tick;
    end
    // Offer a stray byte during FETCH; it must not be consumed
    in_data = 8'h55;
    total++; if (ready_bad != 0) begin bad++; $display("FAIL load_in_ready got %0d low cycles want 0", ready_bad); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_ready_drop got %b want 0", in_ready); end
    total++; if (n_inputs !== exp_inputs) begin
      bad++; $display("FAIL load_pack got lo=%h hi=%h want lo=%h hi=%h", n_inputs[7:0], n_inputs[IC*8-1 -: 8], exp_inputs[7:0], exp_inputs[IC*8-1 -: 8]); end
  endtask

  // Runs one neuron starting at its FETCH cycle; hold=0 keeps out_ready high throughout
  task automatic test_neuron(input int i, input int hold);
    logic [IC*8+7:0] r = row(i);
    logic [7:0] exp_out = 8'h7F - 8'(i);
    int waited = 0;
    int extra_start = 0;
    out_ready = (hold == 0);
    total++; if (w_rd_en !== 1'b1 || w_addr !== IW'(i)) begin
      bad++; $display("FAIL fetch_%0d got rd=%b addr=%0d want 1/%0d", i, w_rd_en, w_addr, i); end
    tick;
    total++; if (n_start !== 1'b0 || w_rd_en !== 1'b0) begin bad++; $display("FAIL wait_mem_%0d got st=%b rd=%b want 0/0", i, n_start, w_rd_en); end
    tick;
    total++; if (n_start !== 1'b1) begin bad++; $display("FAIL start_%0d got %b want 1", i, n_start); end
    total++; if (n_weights !== r[IC*8-1:0] || n_bias !== r[IC*8 +: 8]) begin
      bad++; $display("FAIL weights_%0d got w0=%h b=%h want w0=%h b=%h", i, n_weights[7:0], n_bias, r[7:0], r[IC*8 +: 8]); end
    total++; if (n_inputs !== exp_inputs) begin bad++; $display("FAIL inputs_hold_%0d got lo=%h want lo=%h", i, n_inputs[7:0], exp_inputs[7:0]); end
    tick;
    total++; if (n_start !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL blank_%0d got st=%b ov=%b want 0/0", i, n_start, out_valid); end
    while (n_ready !== 1'b1 && waited < 30) begin
      tick; waited++;
      if (n_start === 1'b1 || out_valid === 1'b1) extra_start++;
    end
    total++; if (waited >= 30 || extra_start != 0) begin
      bad++; $display("FAIL run_%0d got waited=%0d early=%0d want <30/0", i, waited, extra_start); end
    tick;
    total++; if (out_valid !== 1'b1 || out_data !== exp_out || out_index !== IW'(i)) begin
      bad++; $display("FAIL result_%0d got ov=%b d=%h i=%0d want 1/%h/%0d", i, out_valid, out_data, out_index, exp_out, i); end
    if (hold > 0) begin
      int stable_bad = 0;
      for (int c = 0; c < hold; c++) begin
        tick;
        if (out_valid !== 1'b1 || out_data !== exp_out || out_index !== IW'(i) || w_rd_en !== 1'b0) stable_bad++;
      end
      total++; if (stable_bad != 0) begin bad++; $display("FAIL hold_%0d got %0d unstable cycles want 0", i, stable_bad); end
      out_ready = 1'b1;
    end
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL valid_drop_%0d got %b want 0", i, out_valid); end
    if (i == NC - 1) begin
      total++; if (layer_done !== 1'b1 || in_ready !== 1'b1 || w_rd_en !== 1'b0) begin
        bad++; $display("FAIL done_%0d got ld=%b ir=%b rd=%b want 1/1/0", i, layer_done, in_ready, w_rd_en); end
      tick;
      total++; if (layer_done !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL done_pulse got ld=%b ir=%b want 0/1", layer_done, in_ready); end
    end else begin
      total++; if (w_rd_en !== 1'b1 || w_addr !== IW'(i + 1) || layer_done !== 1'b0) begin
        bad++; $display("FAIL next_fetch_%0d got rd=%b addr=%0d ld=%b want 1/%0d/0", i, w_rd_en, w_addr, layer_done, i + 1); end
    end
  endtask

  task automatic test_reset_mid;
    // Walk neuron 1 into RUN, then assert reset between clock edges
    repeat (5) tick;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || n_start !== 1'b0 || w_rd_en !== 1'b0 || layer_done !== 1'b0 || n_inputs !== '0 ||
                 n_weights !== '0 || n_bias !== 8'h00 || out_data !== 8'h00 || out_index !== '0) begin
      bad++; $display("FAIL async_reset got ov=%b st=%b bias=%h od=%h want all 0", out_valid, n_start, n_bias, out_data); end
    tick; tick;
    rst_n = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL post_reset got ir=%b ov=%b want 1/0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset;
    test_load(8'h01, 1'b0);
    test_neuron(0, 0);
    in_valid = 1'b0;
    test_neuron(1, 10);
    test_neuron(2, 3);
    test_load(8'h80, 1'b1);
    in_valid = 1'b0;
    test_neuron(0, 0);
    test_reset_mid;
    test_load(8'h20, 1'b0);
    in_valid = 1'b0;
    test_neuron(0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
